// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD operand sequencer.
//   state_e       : FSM state; its encoding is also the LED "stage" value
//   BCD_MAX_DIGIT : largest legal BCD digit
//   bcd2_valid    : 1 when both nibbles of a byte are legal BCD digits
//   bcd2_tencomp  : 2-digit BCD 10's complement, (100 - x) mod 100
package bcd_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_PRES = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic bit bcd2_valid(input logic [7:0] x);
    return (x[7:4] <= BCD_MAX_DIGIT) && (x[3:0] <= BCD_MAX_DIGIT);
  endfunction

  // 9's complement + 1 with decimal carry. A zero units digit carries into
  // the tens (10 - t); a nonzero one absorbs the +1 (10 - u, tens 9 - t).
  function automatic logic [7:0] bcd2_tencomp(input logic [7:0] x);
    logic [3:0] t;
    logic [3:0] u;
    t = x[7:4];
    u = x[3:0];
    if (u == 4'd0) return {((t == 4'd0) ? 4'd0 : (4'd10 - t)), 4'd0};
    else           return {(4'd9 - t), (4'd10 - u)};
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// ENTER key conditioning: 2-flop synchroniser, optional debouncer, falling-edge
// detect. Produces a registered one-cycle pulse 3 cycles after the key edge
// (plus DEBOUNCE_CYCLES when the debouncer is built).
// Config macro: BCD_DEBOUNCE_EN adds the debouncer.
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   key_n_i        raw active-low key, asynchronous
//   enter_pulse_o  one-cycle press pulse
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic enter_pulse_o
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q, pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef BCD_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Any sample equal to the accepted level restarts the stability count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= sync2_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = level_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);
  assign level = sync2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level;
      pulse_q <= prev_q & ~level;
    end
  end

  assign enter_pulse_o = pulse_q;

endmodule

// File: rtl/bcd_operand_seq.sv
// Operand sequencer for the 2-digit BCD calculator. Latches left then right
// operand from SW_DIGITS on ENTER presses, validates BCD, 10's-complements the
// right operand in subtract mode, and offers the pair over valid/ready.
// Config macro: BCD_DEBOUNCE_EN (debouncer in the key path).
// Ports:
//   CLOCK_50, RESET      clock, synchronous active-high reset
//   KEY_ENTER_N          raw ENTER key, active-low
//   SW_DIGITS, SW_SUB    operand entry and add/subtract select
//   out_left/right/sub   operand pair, out_valid/out_ready handshake
//   bcd_err              last entry was not valid BCD
//   stage                FSM state for LEDs
module bcd_operand_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_ENTER_N,
  input  logic [7:0] SW_DIGITS,
  input  logic       SW_SUB,
  output logic [7:0] out_left,
  output logic [7:0] out_right,
  output logic       out_sub,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       bcd_err,
  output logic [1:0] stage
);

  logic       enter_pulse;
  state_e     state_q;
  logic [7:0] left_q, right_q;
  logic       sub_q, valid_q, err_q;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk_i        (CLOCK_50),
    .rst_i        (RESET),
    .key_n_i      (KEY_ENTER_N),
    .enter_pulse_o(enter_pulse)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= S_A;
      left_q  <= 8'h00;
      right_q <= 8'h00;
      sub_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_A: if (enter_pulse) begin
          if (bcd2_valid(SW_DIGITS)) begin
            left_q  <= SW_DIGITS;
            err_q   <= 1'b0;
            state_q <= S_B;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end
        end
        S_B: if (enter_pulse) begin
          if (bcd2_valid(SW_DIGITS)) begin
            sub_q   <= SW_SUB;
            right_q <= SW_SUB ? bcd2_tencomp(SW_DIGITS) : SW_DIGITS;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_PRES;
          end else begin
            left_q  <= 8'h00;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end
        end
        // Presses here are ignored, including one coincident with the handshake.
        S_PRES: if (valid_q && out_ready) begin
          valid_q <= 1'b0;
          state_q <= S_A;
        end
        S_ERR: if (enter_pulse) begin
          err_q   <= 1'b0;
          state_q <= S_A;
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign out_left  = left_q;
  assign out_right = right_q;
  assign out_sub   = sub_q;
  assign out_valid = valid_q;
  assign bcd_err   = err_q;
  assign stage     = state_q;

endmodule

// File: tb/tb_bcd_operand_seq.sv
module tb_bcd_operand_seq;

`ifdef BCD_DEBOUNCE_EN
  localparam int HOLD = 24;
`else
  localparam int HOLD = 8;
`endif
  localparam int DBC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       sw_sub = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] out_left, out_right;
  logic       out_sub, out_valid, bcd_err;
  logic [1:0] stage;

  bcd_operand_seq #(.DEBOUNCE_CYCLES(DBC)) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .KEY_ENTER_N(key_n),
    .SW_DIGITS  (sw),
    .SW_SUB     (sw_sub),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_sub    (out_sub),
    .out_valid  (out_valid),
    .out_ready  (ready),
    .bcd_err    (bcd_err),
    .stage      (stage)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  typedef struct packed {
    logic [7:0] l;
    logic [7:0] r;
    logic       s;
  } pair_t;
  pair_t exp_q[$];

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic       sub;
    logic [7:0] exp_r;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    pair_t e;
    if (out_valid) valid_cycles++;
    if (out_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got %0h/%0h/%0b expected none", out_left, out_right, out_sub);
      end else begin
        e = exp_q.pop_front();
        chk("pair_left", out_left, e.l);
        chk("pair_right", out_right, e.r);
        chk("pair_sub", out_sub, e.s);
      end
    end
  end

  task automatic press(input logic [7:0] v, input logic s);
    @(posedge clk); #1;
    sw = v; sw_sub = s; key_n = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, %0d pairs pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{8'h45, 8'h32, 1'b0, 8'h32};
    vecs[1] = '{8'h45, 8'h32, 1'b1, 8'h68};
    vecs[2] = '{8'h45, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{8'h45, 8'h01, 1'b1, 8'h99};
    vecs[4] = '{8'h50, 8'h50, 1'b1, 8'h50};
    vecs[5] = '{8'h99, 8'h99, 1'b0, 8'h99};
    vecs[6] = '{8'h73, 8'h10, 1'b1, 8'h90};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stage", stage, 2'd0);
    chk("rst_left", out_left, 8'h00);
    chk("rst_right", out_right, 8'h00);
    chk("rst_sub", out_sub, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_err", bcd_err, 1'b0);

    // Table-driven operand pairs, ready held high
    for (int i = 0; i < 7; i++) begin
      press(vecs[i].l, 1'b0);
      chk("left_stage", stage, 2'd1);
      chk("left_latch", out_left, vecs[i].l);
      valid_cycles = 0;
      exp_q.push_back({vecs[i].l, vecs[i].exp_r, vecs[i].sub});
      press(vecs[i].r, vecs[i].sub);
      wait_drain("vec_drain");
      chk("valid_one_cycle", valid_cycles, 1);
      chk("vec_stage_back", stage, 2'd0);
      chk("vec_valid_low", out_valid, 1'b0);
    end

    // Invalid left entry, then recovery press is not latched
    press(8'h4A, 1'b0);
    chk("err_flag", bcd_err, 1'b1);
    chk("err_stage", stage, 2'd3);
    press(8'h12, 1'b0);
    chk("err_clear", bcd_err, 1'b0);
    chk("err_back_stage", stage, 2'd0);
    chk("err_left_kept", out_left, 8'h73);

    // Invalid right entry
    press(8'h23, 1'b0);
    chk("b_stage", stage, 2'd1);
    press(8'h9F, 1'b0);
    chk("b_err_flag", bcd_err, 1'b1);
    chk("b_err_stage", stage, 2'd3);
    chk("b_no_valid", out_valid, 1'b0);
    press(8'h40, 1'b0);
    chk("b_err_clear", bcd_err, 1'b0);
    chk("b_back_stage", stage, 2'd0);

    // Back-pressure: held pair, extra presses ignored
    @(posedge clk); #1 ready = 1'b0;
    press(8'h27, 1'b0);
    exp_q.push_back({8'h27, 8'h15, 1'b0});
    press(8'h15, 1'b0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_stage", stage, 2'd2);
    press(8'h88, 1'b1);
    press(8'h61, 1'b1);
    press(8'h05, 1'b1);
    chk("bp_valid_held", out_valid, 1'b1);
    chk("bp_left_held", out_left, 8'h27);
    chk("bp_right_held", out_right, 8'h15);
    chk("bp_sub_held", out_sub, 1'b0);
    chk("bp_stage_held", stage, 2'd2);
    @(posedge clk); #1 ready = 1'b1;
    repeat (3) @(negedge clk);
    wait_drain("bp_drain");
    chk("bp_valid_drop", out_valid, 1'b0);
    chk("bp_stage_back", stage, 2'd0);

    // Reset mid-sequence
    press(8'h33, 1'b0);
    chk("mid_stage", stage, 2'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_stage", stage, 2'd0);
    chk("mid_rst_left", out_left, 8'h00);
    chk("mid_rst_right", out_right, 8'h00);
    chk("mid_rst_sub", out_sub, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_err", bcd_err, 1'b0);
    press(8'h56, 1'b0);
    chk("post_rst_stage", stage, 2'd1);
    chk("post_rst_left", out_left, 8'h56);
    exp_q.push_back({8'h56, 8'h89, 1'b1});
    press(8'h11, 1'b1);
    wait_drain("post_rst_drain");
    chk("post_rst_back", stage, 2'd0);

`ifdef BCD_DEBOUNCE_EN
    // Short glitch must not register
    @(posedge clk); #1 sw = 8'h64; key_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("db_glitch_stage", stage, 2'd0);
    // Bouncy press gives exactly one pulse
    @(posedge clk); #1 key_n = 1'b0;
    @(posedge clk); #1 key_n = 1'b1;
    @(posedge clk); #1 key_n = 1'b0;
    @(posedge clk); #1 key_n = 1'b1;
    @(posedge clk); #1 key_n = 1'b0;
    repeat (12) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("db_bounce_stage", stage, 2'd1);
    chk("db_bounce_left", out_left, 8'h64);
    exp_q.push_back({8'h64, 8'h22, 1'b0});
    press(8'h22, 1'b0);
    wait_drain("db_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
